// File: rtl/handshake_rr_mux_pkg.sv
// Shared defaults and the per-channel handshake state type.
package handshake_rr_mux_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_DEPTH  = 4;

    // Four-phase handshake state of one input channel
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is accepted when full only if a pop shares the edge.
module hs_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata_c = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/handshake_rr_mux.sv
// Round-robin merge of four-phase handshake channels into one buffered stream.
module handshake_rr_mux
    import handshake_rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           in_req,
    input  logic [NUM_CH*WIDTH-1:0]     in_data,
    output logic [NUM_CH-1:0]           in_ack,
    input  logic                        out_busy,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic [$clog2(NUM_CH)-1:0]   out_ch,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int unsigned CW = $clog2(NUM_CH);
    localparam int unsigned EW = WIDTH + CW;

    ch_state_e         state     [NUM_CH];
    ch_state_e         state_nxt [NUM_CH];
    logic [CW-1:0]     last_grant;
    logic [NUM_CH-1:0] eligible;
    logic              grant_vld;
    logic [CW-1:0]     grant_idx;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EW-1:0]     push_data;
    logic [EW-1:0]     head;

    assign pop       = !fifo_empty && !out_busy;
    assign push_data = {grant_idx, in_data[32'(grant_idx) * WIDTH +: WIDTH]};

    // Idle channels with a pending request may compete; ack state is exported directly
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            eligible[k] = (state[k] == ST_IDLE) && in_req[k];
            in_ack[k]   = (state[k] == ST_ACK);
        end
    end

    // Round-robin pick starting after the last granted channel, gated by buffer space
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!fifo_full || pop) begin
            for (int unsigned i = 1; i <= NUM_CH; i++) begin
                idx = 32'(last_grant) + i;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (!grant_vld && eligible[CW'(idx)]) begin
                    grant_vld = 1'b1;
                    grant_idx = CW'(idx);
                end
            end
        end
    end

    // Channel FSM next state
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            state_nxt[k] = state[k];
            case (state[k])
                ST_IDLE: if (grant_vld && (grant_idx == CW'(k))) state_nxt[k] = ST_ACK;
                ST_ACK:  if (!in_req[k]) state_nxt[k] = ST_IDLE;
                default: state_nxt[k] = ST_IDLE;
            endcase
        end
    end

    // Channel FSM state and arbiter pointer; reset gives channel 0 first priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) state[k] <= ST_IDLE;
            last_grant <= CW'(NUM_CH - 1);
        end else begin
            for (int k = 0; k < NUM_CH; k++) state[k] <= state_nxt[k];
            if (grant_vld) last_grant <= grant_idx;
        end
    end

    // Output register: one-cycle valid pulse, data and channel hold between pops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            out_valid <= pop;
            if (pop) {out_ch, out_data} <= head;
        end
    end

    hs_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (grant_vld),
        .wdata   (push_data),
        .pop     (pop),
        .rdata_c (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

endmodule

// File: tb/tb_handshake_rr_mux.sv
// Self-checking bench for handshake_rr_mux: vector table, directed corner sequences, random traffic vs queue model.
module tb_handshake_rr_mux;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CW     = 2;
    localparam int unsigned LW     = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       in_req;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ack;
    logic                    out_busy;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [CW-1:0]           out_ch;
    logic [LW-1:0]           level;

    always #5 clk = ~clk;

    handshake_rr_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_busy  (out_busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .level     (level)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of granted words plus per-channel ack flags
    typedef struct {
        int               ch;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t             mq[$];
    bit               m_ack [NUM_CH];
    int               m_last  = NUM_CH - 1;
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_ch    = 0;

    // Producer controls and observed output stream
    int               rem  [NUM_CH];
    bit               hold [NUM_CH];
    int               rate  = 100;
    int               seqno = 1;
    int               outq[$];

    typedef struct {
        logic [NUM_CH-1:0]       req;
        logic                    busy;
        logic [NUM_CH*WIDTH-1:0] data;
        logic [NUM_CH-1:0]       ack;
        logic                    valid;
        logic [WIDTH-1:0]        odata;
        logic [CW-1:0]           och;
        logic [LW-1:0]           lvl;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge: update model from the inputs the edge samples, then compare
    task automatic step();
        ent_t             e;
        bit               pop;
        int               g;
        int               c;
        logic [NUM_CH-1:0] exp_ack;
        if (!rst_n) begin
            mq.delete();
            for (int k = 0; k < NUM_CH; k++) m_ack[k] = 1'b0;
            m_last  = NUM_CH - 1;
            m_valid = 1'b0;
            m_data  = '0;
            m_ch    = 0;
        end else begin
            pop = (mq.size() > 0) && !out_busy;
            g   = -1;
            if ((mq.size() < DEPTH) || pop) begin
                for (int i = 1; i <= NUM_CH; i++) begin
                    c = (m_last + i) % NUM_CH;
                    if (g < 0 && !m_ack[c] && in_req[c]) g = c;
                end
            end
            for (int k = 0; k < NUM_CH; k++)
                if (m_ack[k] && !in_req[k]) m_ack[k] = 1'b0;
            m_valid = 1'b0;
            if (pop) begin
                e       = mq.pop_front();
                m_valid = 1'b1;
                m_data  = e.d;
                m_ch    = e.ch;
            end
            if (g >= 0) begin
                e.ch = g;
                e.d  = in_data[g*WIDTH +: WIDTH];
                mq.push_back(e);
                m_ack[g] = 1'b1;
                m_last   = g;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_CH; k++) exp_ack[k] = m_ack[k];
        chk("in_ack",    32'(in_ack),    32'(exp_ack));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_ch",    32'(out_ch),    32'(m_ch));
        chk("level",     32'(level),     32'(mq.size()));
        if (out_valid) outq.push_back(int'(out_ch));
    endtask

    // Four-phase producers reacting to the DUT acknowledge
    task automatic produce();
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_req[c] && in_ack[c] && !hold[c]) begin
                if ($urandom_range(99) < rate) in_req[c] = 1'b0;
            end else if (!in_req[c] && !in_ack[c] && rem[c] > 0) begin
                if ($urandom_range(99) < rate) begin
                    in_req[c] = 1'b1;
                    in_data[c*WIDTH +: WIDTH] = WIDTH'(seqno);
                    seqno++;
                    rem[c]--;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int c = 0; c < NUM_CH; c++) begin
            rem[c]  = 0;
            hold[c] = 1'b0;
        end
        rate     = 100;
        out_busy = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (in_req == '0 && in_ack == '0 && level == '0) break;
            produce();
            step();
        end
        chk("drain_idle", {in_req, in_ack, 32'(level)}, 32'd0);
    endtask

    initial begin
        int cnt [NUM_CH];
        int exp_order [6];

        rst_n    = 1'b0;
        in_req   = '0;
        in_data  = '0;
        out_busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            rem[c]  = 0;
            hold[c] = 1'b0;
        end

        // Reset state
        step();
        step();
        chk("rst_ack",   32'(in_ack),    32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_ch",    32'(out_ch),    32'd0);
        chk("rst_level", 32'(level),     32'd0);
        rst_n = 1'b1;

        // Single transfer on ch2, then ch0/ch3 contention resolved round-robin from ch3
        tbl[0] = '{4'b0100, 1'b0, 32'h00A5_0000, 4'b0100, 1'b0, 8'h00, 2'd0, 3'd1};
        tbl[1] = '{4'b0100, 1'b0, 32'h00A5_0000, 4'b0100, 1'b1, 8'hA5, 2'd2, 3'd0};
        tbl[2] = '{4'b0000, 1'b0, 32'h00A5_0000, 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0};
        tbl[3] = '{4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0};
        tbl[4] = '{4'b1001, 1'b0, 32'h3300_0011, 4'b1000, 1'b0, 8'h00, 2'd0, 3'd1};
        tbl[5] = '{4'b1001, 1'b0, 32'h3300_0011, 4'b1001, 1'b1, 8'h33, 2'd3, 3'd1};
        tbl[6] = '{4'b0001, 1'b0, 32'h3300_0011, 4'b0001, 1'b1, 8'h11, 2'd0, 3'd0};
        tbl[7] = '{4'b0000, 1'b0, 32'h3300_0011, 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0};
        for (int i = 0; i < 8; i++) begin
            in_req   = tbl[i].req;
            out_busy = tbl[i].busy;
            in_data  = tbl[i].data;
            step();
            chk($sformatf("tbl%0d_ack", i),   32'(in_ack),    32'(tbl[i].ack));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_level", i), 32'(level),     32'(tbl[i].lvl));
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].odata));
                chk($sformatf("tbl%0d_ch", i),   32'(out_ch),   32'(tbl[i].och));
            end
        end

        // Fairness: all channels request continuously
        do_reset();
        for (int c = 0; c < NUM_CH; c++) rem[c] = 1000;
        rate = 100;
        outq.delete();
        for (int n = 0; n < 200 && outq.size() < 40; n++) begin
            produce();
            step();
        end
        chk("fair_words", 32'(outq.size() >= 40), 32'd1);
        if (outq.size() >= 40) begin
            for (int i = 0; i < 5; i++) chk($sformatf("fair_order%0d", i), 32'(outq[i]), 32'(i % NUM_CH));
            for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
            for (int i = 0; i < 40; i++) cnt[outq[i]]++;
            for (int c = 0; c < NUM_CH; c++) chk($sformatf("fair_cnt%0d", c), 32'(cnt[c]), 32'd10);
        end
        drain();

        // Backpressure to full, then release: push and pop share the edge at full
        do_reset();
        out_busy = 1'b1;
        rem[0] = 2; rem[1] = 2; rem[2] = 1; rem[3] = 1;
        rate = 100;
        outq.delete();
        for (int n = 0; n < 12; n++) begin
            produce();
            step();
        end
        chk("bp_level_full", 32'(level),  32'd4);
        chk("bp_ack_wait",   32'(in_ack), 32'd0);
        chk("bp_req_wait",   32'(in_req), 32'b0011);
        out_busy = 1'b0;
        produce();
        step();
        chk("full_pushpop_level", 32'(level),     32'd4);
        chk("full_pushpop_ack0",  32'(in_ack[0]), 32'd1);
        for (int n = 0; n < 30 && outq.size() < 6; n++) begin
            produce();
            step();
        end
        exp_order = '{0, 1, 2, 3, 0, 1};
        chk("bp_words", 32'(outq.size()), 32'd6);
        if (outq.size() >= 6)
            for (int i = 0; i < 6; i++) chk($sformatf("bp_order%0d", i), 32'(outq[i]), 32'(exp_order[i]));
        drain();
        chk("bp_level_empty", 32'(level), 32'd0);

        // Reset with three words buffered and ch1 holding its request
        do_reset();
        out_busy = 1'b1;
        rem[0] = 1; rem[1] = 1; rem[2] = 1; rem[3] = 0;
        hold[1] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            produce();
            step();
        end
        chk("mid_level", 32'(level),     32'd3);
        chk("mid_ack1",  32'(in_ack[1]), 32'd1);
        in_req = 4'b0010;
        rst_n  = 1'b0;
        step();
        chk("mid_rst_level", 32'(level),     32'd0);
        chk("mid_rst_ack",   32'(in_ack),    32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        step();
        chk("regrant_ack", 32'(in_ack), 32'b0010);
        chk("regrant_lvl", 32'(level),  32'd1);
        drain();

        // Random traffic against the model
        for (int c = 0; c < NUM_CH; c++) rem[c] = 100000;
        rate = 60;
        for (int n = 0; n < 800; n++) begin
            out_busy = ($urandom_range(99) < 35);
            produce();
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
